aes256_key_expansion: RTL and testbench

- Computes the AES-256 key schedule (FIPS-197) from a 256-bit cipher key and presents all 15 round keys, plus a valid flag, to the round-key inputs of the 14-round encryption pipeline.
- Sits directly upstream of the encryption pipeline. The pipeline gates its input ready on round_keys_valid.
- Iterative: one 32-bit schedule word per clock, using four shared S-box lookups.

---
 rtl/aes256_key_expansion.sv | 209 ++++++++++++++++++++
 tb/tb_aes256_key_expansion.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/aes256_key_expansion.sv
// ============================================================================
// aes256_key_expansion
// Iterative AES-256 key schedule. It computes one 32-bit schedule word per
// clock and uses four shared S-box lookups. Round keys 0..14 are presented
// to the encryption pipeline, with round_keys_valid set once all 60 words
// are written.
//
// Optional build macro: AES_KEY_ZEROIZE_EN
//   Defining it adds the key_zeroize input. This is a synchronous,
//   active-high erase of all key material, and it returns the block to IDLE.
//   Without it, key material is cleared only by resetn.
// ============================================================================
module aes256_key_expansion #(
    parameter int ROUND_NUMBER = 14,
    parameter int KEY_WIDTH    = 256
) (
    input  logic                         clk,
    input  logic                         resetn,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic                         key_zeroize,
`endif
    input  logic [KEY_WIDTH-1:0]         key_in_tdata,
    input  logic                         key_in_tvalid,
    output logic                         key_in_tready,
    output logic [ROUND_NUMBER:0][127:0] round_keys,
    output logic                         round_keys_valid,
    output logic                         busy
);

    // Only the AES-256 configuration is implemented.
    generate
        if (ROUND_NUMBER != 14 || KEY_WIDTH != 256) begin : g_param_check
            $error("aes256_key_expansion supports only ROUND_NUMBER=14 and KEY_WIDTH=256");
        end
    endgenerate

    localparam int         NUM_WORDS = 4 * (ROUND_NUMBER + 1);
    localparam logic [5:0] FIRST_EXP = 6'd8;
    localparam logic [5:0] LAST_WORD = 6'd59;

    // Forward AES S-box. Entry 0 is held in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Single byte substitution.
    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // SubWord: applies the S-box to each of the four bytes.
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
                sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
    endfunction

    // Round constant for schedule block i/8 (1..7).
    function automatic logic [7:0] rcon(input logic [2:0] idx);
        logic [7:0] r;
        case (idx)
            3'd1:    r = 8'h01;
            3'd2:    r = 8'h02;
            3'd3:    r = 8'h04;
            3'd4:    r = 8'h08;
            3'd5:    r = 8'h10;
            3'd6:    r = 8'h20;
            3'd7:    r = 8'h40;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // The schedule words are the round-key storage. Word j belongs to round
    // j/4 and sits in slot j%4, with slot 0 in the MSBs.
    state_t                       r_state;
    logic [5:0]                   r_word_cnt;
    logic [NUM_WORDS-1:0][31:0]   r_w;
    logic                         r_tready;
    logic                         r_valid;
    logic                         r_busy;

    logic                         w_zeroize;
    logic                         w_handshake;
    logic [31:0]                  w_prev;
    logic [31:0]                  w_back;
    logic [31:0]                  w_sub_src;
    logic [31:0]                  w_sub;
    logic [31:0]                  w_temp;
    logic [31:0]                  w_new;

`ifdef AES_KEY_ZEROIZE_EN
    assign w_zeroize = key_zeroize;
`else
    assign w_zeroize = 1'b0;
`endif

    assign w_handshake = key_in_tvalid & r_tready;

    // Present storage as round keys: round r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
    genvar g_r;
    generate
        for (g_r = 0; g_r <= ROUND_NUMBER; g_r++) begin : g_rk
            assign round_keys[g_r] = {r_w[4*g_r], r_w[4*g_r+1], r_w[4*g_r+2], r_w[4*g_r+3]};
        end
    endgenerate

    assign key_in_tready    = r_tready;
    assign round_keys_valid = r_valid;
    assign busy             = r_busy;

    // Next schedule word w[i] from w[i-1] and w[i-8], using the shared S-boxes.
    always_comb begin
        w_prev    = r_w[r_word_cnt - 6'd1];
        w_back    = r_w[r_word_cnt - 6'd8];
        // RotWord applies only on i%8==0. i%8==4 substitutes the word unrotated.
        if (r_word_cnt[2]) begin
            w_sub_src = w_prev;
        end else begin
            w_sub_src = {w_prev[23:0], w_prev[31:24]};
        end
        w_sub = sub_word(w_sub_src);
        if (r_word_cnt[2:0] == 3'd0) begin
            w_temp = w_sub ^ {rcon(r_word_cnt[5:3]), 24'h000000};
        end else if (r_word_cnt[2:0] == 3'd4) begin
            w_temp = w_sub;
        end else begin
            w_temp = w_prev;
        end
        w_new = w_back ^ w_temp;
    end

    // Control FSM, word writes and registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_word_cnt <= 6'd0;
            r_w        <= '0;
            r_tready   <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else if (w_zeroize) begin
            // Erase wins over any simultaneous key offer.
            r_state    <= ST_IDLE;
            r_word_cnt <= 6'd0;
            r_w        <= '0;
            r_tready   <= 1'b1;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_handshake) begin
                        for (int k = 0; k < 8; k++) begin
                            r_w[k] <= key_in_tdata[KEY_WIDTH-1-32*k -: 32];
                        end
                        r_word_cnt <= FIRST_EXP;
                        r_state    <= ST_EXPAND;
                        r_tready   <= 1'b0;
                        r_valid    <= 1'b0;
                        r_busy     <= 1'b1;
                    end else begin
                        // First cycle after reset release also raises tready here.
                        r_tready   <= 1'b1;
                    end
                end
                ST_EXPAND: begin
                    r_w[r_word_cnt] <= w_new;
                    if (r_word_cnt == LAST_WORD) begin
                        r_state  <= ST_DONE;
                        r_tready <= 1'b1;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_word_cnt <= r_word_cnt + 6'd1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_word_cnt <= 6'd0;
                    r_tready   <= 1'b1;
                    r_valid    <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes256_key_expansion.sv
// ============================================================================
// tb_aes256_key_expansion
// Directed-vector bench for aes256_key_expansion. It uses the FIPS-197 A.3
// key and the all-zero key. It covers rekey from DONE, reset during
// expansion and, with AES_KEY_ZEROIZE_EN, zeroize.
// ============================================================================
module tb_aes256_key_expansion;

    localparam logic [255:0] KEY_A3   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY_ZERO = 256'h0;

    localparam logic [127:0] A3_RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] A3_RK1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] A3_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] A3_RK3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
    localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] Z_RK2   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK3   = 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb;

    logic                 clk;
    logic                 resetn;
    logic [255:0]         key_in_tdata;
    logic                 key_in_tvalid;
    logic                 key_in_tready;
    logic [14:0][127:0]   round_keys;
    logic                 round_keys_valid;
    logic                 busy;
`ifdef AES_KEY_ZEROIZE_EN
    logic                 key_zeroize;
`endif

    int n_checks;
    int n_pass;
    int lat;

    aes256_key_expansion #(
        .ROUND_NUMBER (14),
        .KEY_WIDTH    (256)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
`ifdef AES_KEY_ZEROIZE_EN
        .key_zeroize      (key_zeroize),
`endif
        .key_in_tdata     (key_in_tdata),
        .key_in_tvalid    (key_in_tvalid),
        .key_in_tready    (key_in_tready),
        .round_keys       (round_keys),
        .round_keys_valid (round_keys_valid),
        .busy             (busy)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Offer a key for one edge, then count edges until valid rises (bounded).
    // When pulse is set, tvalid is raised with the A.3 key at expansion edges 10..12.
    task automatic run_key(input logic [255:0] key, input bit pulse, output int latency);
        key_in_tdata  = key;
        key_in_tvalid = 1'b1;
        @(posedge clk); #1;
        key_in_tvalid = 1'b0;
        check("accept_tready_low", 128'(key_in_tready), 128'd0);
        check("accept_busy_high", 128'(busy), 128'd1);
        check("accept_valid_low", 128'(round_keys_valid), 128'd0);
        latency = 0;
        for (int n = 1; n <= 60; n++) begin
            if (pulse && n >= 10 && n <= 12) begin
                key_in_tdata  = KEY_A3;
                key_in_tvalid = 1'b1;
            end else begin
                key_in_tvalid = 1'b0;
            end
            @(posedge clk); #1;
            if (pulse && n == 11) begin
                check("mid_tready_low", 128'(key_in_tready), 128'd0);
            end
            if (round_keys_valid) begin
                latency = n;
                break;
            end
        end
        key_in_tvalid = 1'b0;
        check("done_busy_low", 128'(busy), 128'd0);
        check("done_tready_high", 128'(key_in_tready), 128'd1);
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        resetn        = 1'b0;
        key_in_tvalid = 1'b0;
        key_in_tdata  = '0;
`ifdef AES_KEY_ZEROIZE_EN
        key_zeroize   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", 128'(key_in_tready), 128'd0);
        check("rst_valid", 128'(round_keys_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        resetn = 1'b1;

        // Idle for 10 cycles with no key offered
        repeat (10) @(posedge clk);
        #1;
        check("idle_tready", 128'(key_in_tready), 128'd1);
        check("idle_valid", 128'(round_keys_valid), 128'd0);
        check("idle_busy", 128'(busy), 128'd0);
        check("idle_rk_zero", 128'(|round_keys), 128'd0);

        // FIPS-197 A.3 key
        run_key(KEY_A3, 1'b0, lat);
        check("a3_latency", 128'(lat), 128'd52);
        check("a3_rk0", round_keys[0], A3_RK0);
        check("a3_rk1", round_keys[1], A3_RK1);
        check("a3_rk2", round_keys[2], A3_RK2);
        check("a3_rk3", round_keys[3], A3_RK3);
        check("a3_rk14", round_keys[14], A3_RK14);

        // Hold in DONE: keys stable, valid stays high
        repeat (3) @(posedge clk);
        #1;
        check("hold_valid", 128'(round_keys_valid), 128'd1);
        check("hold_rk14", round_keys[14], A3_RK14);

        // Rekey from DONE with the zero key; mid-expansion tvalid pulses ignored
        run_key(KEY_ZERO, 1'b1, lat);
        check("zero_latency", 128'(lat), 128'd52);
        check("zero_rk0", round_keys[0], 128'd0);
        check("zero_rk1", round_keys[1], 128'd0);
        check("zero_rk2", round_keys[2], Z_RK2);
        check("zero_rk3", round_keys[3], Z_RK3);

        // Reset at expansion cycle 20
        key_in_tdata  = KEY_A3;
        key_in_tvalid = 1'b1;
        @(posedge clk); #1;
        key_in_tvalid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("abort_valid", 128'(round_keys_valid), 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_tready", 128'(key_in_tready), 128'd0);
        check("abort_rk_zero", 128'(|round_keys), 128'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_abort_tready", 128'(key_in_tready), 128'd1);
        check("post_abort_valid", 128'(round_keys_valid), 128'd0);
        run_key(KEY_A3, 1'b0, lat);
        check("re_a3_latency", 128'(lat), 128'd52);
        check("re_a3_rk2", round_keys[2], A3_RK2);
        check("re_a3_rk14", round_keys[14], A3_RK14);

`ifdef AES_KEY_ZEROIZE_EN
        // Zeroize in DONE
        key_zeroize = 1'b1;
        @(posedge clk); #1;
        key_zeroize = 1'b0;
        check("zz_rk_zero", 128'(|round_keys), 128'd0);
        check("zz_valid", 128'(round_keys_valid), 128'd0);
        check("zz_busy", 128'(busy), 128'd0);
        check("zz_tready", 128'(key_in_tready), 128'd1);
        // Zeroize together with a handshake: the key is not taken
        key_zeroize   = 1'b1;
        key_in_tdata  = KEY_A3;
        key_in_tvalid = 1'b1;
        @(posedge clk); #1;
        key_zeroize   = 1'b0;
        key_in_tvalid = 1'b0;
        check("zz_hs_busy", 128'(busy), 128'd0);
        check("zz_hs_rk_zero", 128'(|round_keys), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        check("zz_hs_still_idle", 128'(busy), 128'd0);
        check("zz_hs_no_valid", 128'(round_keys_valid), 128'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
